reset_sequencer: RTL
====================

# reset_sequencer

Single-clock controller that generates the per-domain reset lines feeding the asynchronously reset registers of downstream blocks. It holds every domain in reset after power-on, releases the domains one at a time at a fixed stagger, and serves software reset requests with a quiesce handshake and timeout before re-asserting reset. Its outputs are registered, so they drive `rst` pins of async-reset registers glitch-free. Downstream blocks still synchronize deassertion locally.

## Interface
- `NUM_DOMAINS`, 4: number of reset domains, 1..32.
- `HOLD_CYCLES`, 16: cycles all domains are held in reset before release begins, 1..65535.
- `STAGGER_CYCLES`, 4: cycles between successive domain releases, 1..65535.
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting for quiesce acknowledgement, 1..65535.

- `clk`  in  1  sole clock. All state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw_req`  in  1  software reset request. Sampled only in IDLE.
- `quiesce_ack`  in  NUM_DOMAINS  per-domain acknowledgement that the domain is idle. Level signal.
- `quiesce_req`  out  NUM_DOMAINS  request to domains to drain.
- `domain_rst`  out  NUM_DOMAINS  active-high reset per domain. Bit i drives domain i.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when the last domain is released.
- `timeout`  out  1  sticky flag: the last drain ended by timeout.

## Operation
- States: IDLE, DRAIN, ASSERT, RELEASE, DONE.
- `busy` and `done` decode the state register: `busy` = (state != IDLE), `done` = (state == DONE). `domain_rst`, `quiesce_req` and `timeout` are flops.
- Internal registers: a 16-bit counter `cnt` and a domain index `idx` (width clog2(NUM_DOMAINS), minimum 1).
- `rst` = 1, in any state: next state ASSERT, `cnt` = 0, `idx` = 0, `domain_rst` = all ones, `quiesce_req` = 0, `timeout` = 0. Reset values: `busy` = 1, `done` = 0.
- IDLE, `sw_req` = 1: go to DRAIN, `cnt` = 0, `quiesce_req` = all ones, `timeout` = 0.
- `sw_req` outside IDLE is ignored, including during the DONE cycle. Requests are not queued.
- DRAIN, exit when `quiesce_ack` is all ones in one cycle:
  - Go to ASSERT, `cnt` = 0, `domain_rst` = all ones, `quiesce_req` = 0.
  - Partial acks do not count. Acks must be simultaneous.
- DRAIN, exit on timeout when `cnt` == TIMEOUT_CYCLES-1 and acks are not all ones:
  - Same transition as above, and `timeout` = 1.
  - All-ones acks in the terminal cycle win, so `timeout` stays 0.
- ASSERT: `cnt` increments each cycle. At `cnt` == HOLD_CYCLES-1, go to RELEASE with `cnt` = 0 and `idx` = 0.
- RELEASE: `cnt` increments. At `cnt` == STAGGER_CYCLES-1:
  - `domain_rst[idx]` is cleared, `cnt` = 0, `idx` increments.
  - If `idx` == NUM_DOMAINS-1, go to DONE.
- Release order is always domain 0 first, ascending.
- DONE: lasts one cycle, then IDLE. `domain_rst` stays all zeros in IDLE.

## Timing
- Cycle 0 is the first cycle in ASSERT, either after `rst` drops or after a DRAIN exit.
- Domain i reads `domain_rst[i]` = 0 starting at cycle HOLD_CYCLES + (i+1)*STAGGER_CYCLES.
- `done` is high exactly at cycle HOLD_CYCLES + NUM_DOMAINS*STAGGER_CYCLES, the same cycle the last domain is released. `busy` is 0 from the following cycle.
- `sw_req` high in IDLE at cycle t: `quiesce_req` and `busy` are high at t+1.
- If acks are all ones at cycle t+1+a, then `domain_rst` = all ones and `quiesce_req` = 0 at t+2+a.
- Worst-case drain: TIMEOUT_CYCLES cycles in DRAIN.
- Each output bit changes at most once per state visit.
- `rst` asserted mid-sequence restarts the full hold-and-release sequence. No partial release persists.

## Test plan
- Power-on, defaults: hold `rst` 3 cycles, then release.
  - `domain_rst` = 4'b1111 through cycle 19.
  - Becomes 1110 at 20, 1100 at 24, 1000 at 28, 0000 at 32.
  - `done` high only at 32. `busy` low from 33.
- Software reset, clean drain: in IDLE, pulse `sw_req` at t and raise all acks at t+3.
  - `quiesce_req` = 1111 over t+1..t+3.
  - `domain_rst` = 1111 at t+4. Domain 0 releases at t+24. `timeout` = 0.
- Drain timeout: `TIMEOUT_CYCLES` = 8, ack only domains 0 and 1.
  - DRAIN spans t+1..t+8. Domain reset asserts at t+9. `timeout` = 1 until the next accepted `sw_req`.
- Ack arrives in the terminal cycle: all acks first go high at t+8 with `TIMEOUT_CYCLES` = 8.
  - `timeout` = 0 and ASSERT is entered at t+9.
- Mid-operation reset and ignored request:
  - Pulse `sw_req` during RELEASE: no effect, `done` still at 32.
  - Pulse `rst` at cycle 26: `domain_rst` returns to 1111, and release restarts at 20 cycles after `rst` drops.
- Edge parameters: `NUM_DOMAINS` = 1, `HOLD_CYCLES` = 1, `STAGGER_CYCLES` = 1.
  - `domain_rst` = 1 at cycle 0, 0 at cycle 2. `done` at cycle 2.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer, software and the reset domains.
// master: the sequencer side. slave: software plus the domains it controls.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   sw_req;
  logic [NUM_DOMAINS-1:0] quiesce_ack;
  logic [NUM_DOMAINS-1:0] quiesce_req;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   busy;
  logic                   done;
  logic                   timeout;

  modport master (
    input  sw_req, quiesce_ack,
    output quiesce_req, domain_rst, busy, done, timeout
  );

  modport slave (
    output sw_req, quiesce_ack,
    input  quiesce_req, domain_rst, busy, done, timeout
  );
endinterface

// File: rtl/reset_sequencer.sv
// Per-domain reset generator. Holds all domains in reset, releases them one at
// a time in ascending order, and serves software reset requests with a
// quiesce/drain handshake bounded by a timeout. All outputs come from flops or
// from a direct decode of the state register, so they are glitch-free.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.master bus
);

  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DRAIN   = 3'd1;
  localparam logic [2:0] ASSERT  = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]             state_reg, state_next;
  logic [15:0]            cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [NUM_DOMAINS-1:0] domain_rst_reg, domain_rst_next;
  logic [NUM_DOMAINS-1:0] quiesce_req_reg, quiesce_req_next;
  logic                   timeout_reg, timeout_next;

  logic [NUM_DOMAINS-1:0] release_sel;
  logic                   all_ack;
  logic                   drain_expired;
  logic                   hold_done;
  logic                   stagger_done;
  logic                   last_domain;

  // One-hot select of the domain currently due for release.
  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_sel
    assign release_sel[gi] = (idx_reg == IDX_W'(gi));
  end

  assign all_ack       = &bus.quiesce_ack;
  assign drain_expired = (cnt_reg == 16'(TIMEOUT_CYCLES - 1));
  assign hold_done     = (cnt_reg == 16'(HOLD_CYCLES - 1));
  assign stagger_done  = (cnt_reg == 16'(STAGGER_CYCLES - 1));
  assign last_domain   = (idx_reg == IDX_W'(NUM_DOMAINS - 1));

  // Next-state and output-flop logic for the drain / hold / staggered release sequence.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    idx_next         = idx_reg;
    domain_rst_next  = domain_rst_reg;
    quiesce_req_next = quiesce_req_reg;
    timeout_next     = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (bus.sw_req) begin
          state_next       = DRAIN;
          cnt_next         = '0;
          quiesce_req_next = '1;
          timeout_next     = 1'b0;
        end
      end
      DRAIN: begin
        cnt_next = cnt_reg + 16'd1;
        // A full simultaneous ack in the terminal cycle counts as a clean drain.
        if (all_ack || drain_expired) begin
          state_next       = ASSERT;
          cnt_next         = '0;
          domain_rst_next  = '1;
          quiesce_req_next = '0;
          timeout_next     = !all_ack;
        end
      end
      ASSERT: begin
        cnt_next = cnt_reg + 16'd1;
        if (hold_done) begin
          state_next = RELEASE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      RELEASE: begin
        cnt_next = cnt_reg + 16'd1;
        if (stagger_done) begin
          cnt_next        = '0;
          idx_next        = idx_reg + 1'b1;
          domain_rst_next = domain_rst_reg & ~release_sel;
          if (last_domain) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = ASSERT;
      end
    endcase
  end

  // State and output registers; rst restarts the whole hold-and-release sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ASSERT;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      domain_rst_reg  <= '1;
      quiesce_req_reg <= '0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      domain_rst_reg  <= domain_rst_next;
      quiesce_req_reg <= quiesce_req_next;
      timeout_reg     <= timeout_next;
    end
  end

  assign bus.domain_rst  = domain_rst_reg;
  assign bus.quiesce_req = quiesce_req_reg;
  assign bus.timeout     = timeout_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = (state_reg == DONE);

endmodule
